// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffered command FIFO in front of an N-bit combinational ALU, with a
// one-entry registered result stage behind it. Both sides use a valid/ready handshake.
// Optional feature macro: ALU_SEQ_STATUS_EN adds the registered res_zero_o / res_illegal_o flags.
module alu_cmd_sequencer #(
   parameter int unsigned N     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         cmd_valid_i,
   output logic         cmd_ready_o,
   input  logic [N-1:0] cmd_a_i,
   input  logic [N-1:0] cmd_b_i,
   input  logic [2:0]   cmd_op_i,
   output logic         res_valid_o,
   input  logic         res_ready_i,
   output logic [N-1:0] res_data_o,
   output logic [2:0]   res_op_o
`ifdef ALU_SEQ_STATUS_EN
   ,
   output logic         res_zero_o,
   output logic         res_illegal_o
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

   typedef enum logic {StEmpty, StFull} state_e;

   logic [N-1:0]  a_mem_q  [DEPTH];
   logic [N-1:0]  b_mem_q  [DEPTH];
   logic [2:0]    op_mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   state_e        state_q;
   logic [N-1:0]  res_data_q;
   logic [2:0]    res_op_q;

   logic          push, issue;
   logic [N-1:0]  head_a, head_b;
   logic [2:0]    head_op;
   logic [N-1:0]  alu_res;

   // Ready depends only on registered occupancy, so a full FIFO never accepts on a pop cycle.
   assign cmd_ready_o = (count_q < DepthCnt);

   assign push  = cmd_valid_i && cmd_ready_o && !flush_i;
   assign issue = (count_q != '0) && ((state_q == StEmpty) || res_ready_i) && !flush_i;

   assign head_a  = a_mem_q[rd_ptr_q];
   assign head_b  = b_mem_q[rd_ptr_q];
   assign head_op = op_mem_q[rd_ptr_q];

   // Combinational ALU on the FIFO head; carry and borrow are dropped by the N-bit result.
   always_comb begin
      alu_res = '1;
      unique case (head_op)
         3'b000:  alu_res = head_a + head_b;
         3'b001:  alu_res = head_a - head_b;
         3'b010:  alu_res = head_a & head_b;
         3'b011:  alu_res = head_a ^ head_b;
         default: alu_res = '1;
      endcase
   end

   // Occupancy next-state: flush wins, simultaneous push and pop leave the count unchanged.
   always_comb begin
      count_d = count_q;
      if (flush_i) begin
         count_d = '0;
      end else if (push && !issue) begin
         count_d = count_q + (AW + 1)'(1);
      end else if (!push && issue) begin
         count_d = count_q - (AW + 1)'(1);
      end
   end

   // FIFO storage and pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            a_mem_q[i]  <= '0;
            b_mem_q[i]  <= '0;
            op_mem_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               a_mem_q[wr_ptr_q]  <= cmd_a_i;
               b_mem_q[wr_ptr_q]  <= cmd_b_i;
               op_mem_q[wr_ptr_q] <= cmd_op_i;
               wr_ptr_q           <= wr_ptr_q + AW'(1);
            end
            if (issue) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
            end
         end
      end
   end

`ifdef ALU_SEQ_STATUS_EN
   logic res_zero_q, res_illegal_q;
   assign res_zero_o    = res_zero_q;
   assign res_illegal_o = res_illegal_q;
`endif

   // Output stage FSM with its registered result; res_data holds its value when the stage empties.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StEmpty;
         res_data_q <= '0;
         res_op_q   <= '0;
`ifdef ALU_SEQ_STATUS_EN
         res_zero_q    <= 1'b0;
         res_illegal_q <= 1'b0;
`endif
      end else if (flush_i) begin
         state_q <= StEmpty;
`ifdef ALU_SEQ_STATUS_EN
         res_zero_q    <= 1'b0;
         res_illegal_q <= 1'b0;
`endif
      end else begin
         if (issue) begin
            state_q    <= StFull;
            res_data_q <= alu_res;
            res_op_q   <= head_op;
`ifdef ALU_SEQ_STATUS_EN
            res_zero_q    <= (alu_res == '0);
            res_illegal_q <= (head_op > 3'b011);
`endif
         end else if ((state_q == StFull) && res_ready_i) begin
            // Reaching here in StFull means the FIFO is empty.
            state_q <= StEmpty;
         end
      end
   end

   assign res_valid_o = (state_q == StFull);
   assign res_data_o  = res_data_q;
   assign res_op_o    = res_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random traffic, all
// compared against a transaction-level queue model. Honours ALU_SEQ_STATUS_EN if defined.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a, cmd_b;
   logic [2:0] cmd_op;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [2:0] res_op;
`ifdef ALU_SEQ_STATUS_EN
   logic       res_zero, res_illegal;
`endif

   alu_cmd_sequencer #(.N(8), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .flush_i     (flush),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_a_i     (cmd_a),
      .cmd_b_i     (cmd_b),
      .cmd_op_i    (cmd_op),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .res_data_o  (res_data),
      .res_op_o    (res_op)
`ifdef ALU_SEQ_STATUS_EN
      ,
      .res_zero_o    (res_zero),
      .res_illegal_o (res_illegal)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue of pending commands plus the held result.
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
   } cmd_t;

   cmd_t       mq[$];
   logic       m_valid;
   logic [7:0] m_data;
   logic [2:0] m_op;

   function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
      int ia = int'(a);
      int ib = int'(b);
      case (op)
         3'd0:    return 8'((ia + ib) % 256);
         3'd1:    return 8'((ia - ib + 256) % 256);
         3'd2:    return a & b;
         3'd3:    return a ^ b;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_reset();
      mq.delete();
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_op    = 3'd0;
   endtask

   task automatic compare_outputs(input string where);
      check_eq({where, ":res_valid"}, 32'(res_valid), 32'(m_valid));
      check_eq({where, ":cmd_ready"}, 32'(cmd_ready), 32'(mq.size() < DEPTH));
      if (m_valid) begin
         check_eq({where, ":res_data"}, 32'(res_data), 32'(m_data));
         check_eq({where, ":res_op"}, 32'(res_op), 32'(m_op));
`ifdef ALU_SEQ_STATUS_EN
         check_eq({where, ":res_zero"}, 32'(res_zero), 32'(m_data == 8'h00));
         check_eq({where, ":res_illegal"}, 32'(res_illegal), 32'(m_op > 3'd3));
`endif
      end
   endtask

   // One clock: drive inputs, advance the model, then compare just after the edge.
   task automatic step(input string where, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] op, input logic rr,
                       input logic fl);
      logic accept;
      cmd_t c;
      cmd_valid = v;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      res_ready = rr;
      flush     = fl;
      accept    = v && (mq.size() < DEPTH);
      if (fl) begin
         mq.delete();
         m_valid = 1'b0;
      end else begin
         if (mq.size() > 0 && (!m_valid || rr)) begin
            c       = mq.pop_front();
            m_data  = ref_alu(c.a, c.b, c.op);
            m_op    = c.op;
            m_valid = 1'b1;
         end else if (m_valid && rr) begin
            m_valid = 1'b0;
         end
         if (accept) begin
            c.a  = a;
            c.b  = b;
            c.op = op;
            mq.push_back(c);
         end
      end
      @(posedge clk);
      #1;
      compare_outputs(where);
   endtask

   task automatic idle(input string where, input logic rr);
      step(where, 1'b0, 8'h00, 8'h00, 3'd0, rr, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = '0;
      res_ready = 1'b0;
      model_reset();
      #12;
      check_eq("rst:res_valid", 32'(res_valid), 32'd0);
      check_eq("rst:res_data", 32'(res_data), 32'd0);
      check_eq("rst:res_op", 32'(res_op), 32'd0);
      check_eq("rst:cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef ALU_SEQ_STATUS_EN
      check_eq("rst:res_zero", 32'(res_zero), 32'd0);
      check_eq("rst:res_illegal", 32'(res_illegal), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First command: result one cycle after acceptance.
      step("add_push", 1'b1, 8'h05, 8'h03, 3'd0, 1'b1, 1'b0);
      check_eq("add_lat0:res_valid", 32'(res_valid), 32'd0);
      idle("add_res", 1'b1);
      check_eq("add:res_data", 32'(res_data), 32'h08);
      check_eq("add:res_valid", 32'(res_valid), 32'd1);
      idle("add_drain", 1'b1);

      // Wrap and opcode coverage.
      step("sub_push", 1'b1, 8'h00, 8'h01, 3'd1, 1'b1, 1'b0);
      step("addw_push", 1'b1, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);
      check_eq("sub_wrap:res_data", 32'(res_data), 32'hFF);
      step("ill_push", 1'b1, 8'h12, 8'h34, 3'd6, 1'b1, 1'b0);
      check_eq("add_wrap:res_data", 32'(res_data), 32'h00);
`ifdef ALU_SEQ_STATUS_EN
      check_eq("add_wrap:res_zero", 32'(res_zero), 32'd1);
`endif
      idle("ill_res", 1'b1);
      check_eq("illegal:res_data", 32'(res_data), 32'hFF);
`ifdef ALU_SEQ_STATUS_EN
      check_eq("illegal:res_illegal", 32'(res_illegal), 32'd1);
`endif
      idle("ill_drain", 1'b1);

      // Fill under backpressure, then drain in order.
      for (int i = 1; i <= 5; i++) begin
         step("fill", 1'b1, 8'(i), 8'h01, 3'd0, 1'b0, 1'b0);
      end
      check_eq("fill:cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("fill:held_data", 32'(res_data), 32'h02);
      step("fill_reject", 1'b1, 8'hAA, 8'h01, 3'd0, 1'b0, 1'b0);
      check_eq("fill_reject:cmd_ready", 32'(cmd_ready), 32'd0);
      for (int j = 1; j <= 4; j++) begin
         idle("drain", 1'b1);
         check_eq("drain:order", 32'(res_data), 32'(j + 2));
      end
      idle("drain_last", 1'b1);
      check_eq("drain_end:res_valid", 32'(res_valid), 32'd0);

      // Streaming: one result per cycle, FIFO never backs up.
      for (int i = 0; i < 16; i++) begin
         step("stream", 1'b1, 8'(i), 8'(2 * i), 3'(i % 4), 1'b1, 1'b0);
         if (i > 0) begin
            check_eq("stream:res_valid", 32'(res_valid), 32'd1);
         end
      end
      idle("stream_tail", 1'b1);
      idle("stream_done", 1'b1);

      // Flush with three buffered commands and a held result.
      for (int i = 0; i < 4; i++) begin
         step("pre_flush", 1'b1, 8'h10 + 8'(i), 8'h01, 3'd0, 1'b0, 1'b0);
      end
      step("flush", 1'b1, 8'h77, 8'h77, 3'd0, 1'b0, 1'b1);
      check_eq("flush:res_valid", 32'(res_valid), 32'd0);
      check_eq("flush:cmd_ready", 32'(cmd_ready), 32'd1);
      step("post_flush_push", 1'b1, 8'h40, 8'h02, 3'd1, 1'b1, 1'b0);
      idle("post_flush_res", 1'b1);
      check_eq("post_flush:res_data", 32'(res_data), 32'h3E);
      idle("post_flush_empty", 1'b1);
      check_eq("post_flush:res_valid", 32'(res_valid), 32'd0);

      // Asynchronous reset between edges during streaming.
      for (int i = 0; i < 3; i++) begin
         step("pre_rst", 1'b1, 8'h20 + 8'(i), 8'h03, 3'd2, 1'b0, 1'b0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst:res_valid", 32'(res_valid), 32'd0);
      check_eq("arst:res_data", 32'(res_data), 32'd0);
      check_eq("arst:res_op", 32'(res_op), 32'd0);
      check_eq("arst:cmd_ready", 32'(cmd_ready), 32'd1);
      model_reset();
      cmd_valid = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle("post_rst", 1'b1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
              3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 99) < 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Buffered command front-end and result back-end wrapped around the team's N-bit ALU (`alu_structural`). Accepts {a, b, opcode} commands over a valid/ready handshake into a DEPTH-entry FIFO. Pops one command per cycle into the combinational ALU and registers each result into a one-entry output stage with its own valid/ready handshake. This decouples the combinational ALU from its producer and its consumer.

## Interface
- N, 8, operand/result width
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of FIFO and output stage
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept
- cmd_a  in  N  operand A
- cmd_b  in  N  operand B
- cmd_op  in  3  opcode
- res_valid  out  1  res_data holds an unconsumed result
- res_ready  in  1  consumer takes result
- res_data  out  N  registered ALU result
- res_op  out  3  opcode that produced res_data
- res_zero  out  1  (ALU_SEQ_STATUS_EN only) res_data == 0
- res_illegal  out  1  (ALU_SEQ_STATUS_EN only) res_op > 3'b011

## Operation
- Reset values: cmd_ready=1, res_valid=0, res_data=0, res_op=0, res_zero=0, res_illegal=0, FIFO count=0, pointers=0.
- Push: cmd_valid && cmd_ready at an edge writes {a,b,op} at wr_ptr and increments wr_ptr (mod DEPTH).
- cmd_ready = (count < DEPTH). It is derived from registered count only. No combinational path from res_ready. When full, a same-cycle pop does not admit a push.
- Output stage FSM, two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- Issue condition: count>0 && (state==EMPTY || res_ready).
  - On issue, the head entry drives the ALU. res_data/res_op load the ALU result and head opcode. rd_ptr increments.
  - State goes to or stays FULL.
- FULL && res_ready && count==0: go to EMPTY. res_data holds its last value.
- FULL && !res_ready: res_data/res_op stable and the FIFO is not popped (backpressure).
- ALU function, result modulo 2^N:
  - 000: a+b
  - 001: a−b
  - 010: a&b
  - 011: a^b
  - 100–111: all ones.
  - Carry and borrow are discarded.
- Simultaneous push and pop: count unchanged, both pointers advance.
- flush=1: count, pointers and state are cleared to reset values, and res_valid=0 next cycle. A command presented in the same cycle is dropped. flush has priority over push and pop.
- Asynchronous reset mid-operation discards all buffered commands and any pending result immediately.

## Timing
- Latency: a command accepted at edge k into an empty FIFO with output EMPTY appears with res_valid=1 after edge k+1.
- Throughput: one result per cycle while cmd_valid and res_ready are held high.
- res_data, res_op and the status flags are registered outputs. cmd_ready is registered-state-derived.
- Output stays stable from the edge res_valid rises until the edge where res_valid && res_ready.

## Configuration
- ALU_SEQ_STATUS_EN defined:
  - Ports res_zero and res_illegal exist.
  - Both are registered alongside res_data on issue and cleared by reset and flush.
- ALU_SEQ_STATUS_EN undefined:
  - Both ports and their registers are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then push {a=8'h05, b=8'h03, op=000} with res_ready=1 → res_valid high one cycle after acceptance, res_data=8'h08, res_op=000.
- Wrap and opcode coverage:
  - sub 8'h00−8'h01 → 8'hFF
  - add 8'hFF+8'h01 → 8'h00 (res_zero=1 when enabled)
  - op=3'b110 → 8'hFF (res_illegal=1).
- Fill: res_ready=0, push 5 commands back to back → cmd_ready low after DEPTH entries are buffered with one result held. Then raise res_ready → results drain in order, one per cycle, values match the push order.
- Streaming: cmd_valid=1 and res_ready=1 for 16 cycles with incrementing operands → 16 results on consecutive cycles, count never exceeds 1.
- flush asserted with 3 entries buffered and res_valid=1 → next cycle res_valid=0, cmd_ready=1. The next push yields only its own result.
- rst_n pulsed low mid-stream (asynchronously, between edges) → outputs return to reset values immediately. No stale result appears after release.
